ibex_mem_responder: RTL and testbench
=====================================

# ibex_mem_responder

Simulation and FPGA memory responder for the Ibex instruction and data bus (req/gnt/rvalid protocol). It is the responder end of the core's memory interfaces: it accepts requests, grants them, and returns read data or write completions after a fixed latency. Backpressure is programmable. One instance is placed on each of the core's instruction and data ports in testbenches and small FPGA tops.

## Interface
Parameters:
- MemWords, 1024 — memory depth in 32-bit words; power of two, ≥ 2.
- BaseAddr, 32'h0 — byte address of word 0; aligned to MemWords*4.
- Latency, 1 — cycles from grant to rvalid; range 1..8.
- MaxOutstanding, 2 — granted-but-unanswered request limit; range 1..Latency+1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; **one clock; reset is synchronous and active-low**.
- req_i  in  1  request valid.
- gnt_o  out  1  request accepted this cycle.
- addr_i  in  32  byte address; bits [1:0] ignored.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables; used for writes only.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- err_o  out  1  response error; qualified by rvalid_o.
- stall_i  in  1  bench backpressure; forces gnt_o low.
- err_inject_i  in  1  error injection request; see Configuration.

## Operation
- Grant: gnt_o = req_i & ~stall_i & (outstanding < MaxOutstanding). gnt_o is combinational, so a grant can occur in the same cycle as the request.
- Range check: a request is in range when BaseAddr ≤ addr_i < BaseAddr + MemWords*4. Word index = (addr_i − BaseAddr) >> 2.
- Granted write, in range:
  - Each byte lane with be_i[k]=1 is written at the grant clock edge.
  - Bytes with be_i[k]=0 are left unchanged.
  - be_i = 0 still completes normally.
- Granted read, in range: the word is sampled at the grant cycle, after any write granted in an earlier cycle. Read-after-write therefore returns the new data.
- Out-of-range request:
  - Writes are dropped.
  - The response carries err_o=1 and rdata_o=0.
- Response pipeline: a Latency-deep shift register of {valid, err, rdata}.
  - Every grant produces exactly one response; responses return in order.
  - rdata_o = 0 for write responses and whenever rvalid_o=0.
- Outstanding counter:
  - Increments on gnt_o and decrements on rvalid_o.
  - When both happen in the same cycle, the count is unchanged.
  - It never exceeds MaxOutstanding and never goes below 0.
- Reset:
  - Clears the response pipeline and the counter; pending responses are discarded.
  - Does not clear the memory array. Writes granted before reset persist.
- Reset values: gnt_o follows its equation (0 when req_i=0); rvalid_o=0, rdata_o=0, err_o=0.

## Timing
- Grant in cycle T → rvalid_o high in cycle T+Latency for exactly one cycle.
- Back-to-back grants are allowed every cycle while outstanding < MaxOutstanding.
  - Sustained throughput is 1 per cycle when MaxOutstanding = Latency+1.
  - Sustained throughput is lower for smaller MaxOutstanding values.
- At the limit, the cycle in which rvalid_o retires a request still sees the old count, so gnt_o=0 in that cycle. The grant is re-enabled the following cycle.
- stall_i takes effect in the same cycle. Address, data and byte-enable inputs are sampled only in the grant cycle.
- An assertion of rst_ni=0 at any edge leaves rvalid_o=0 in the next cycle, regardless of pipeline contents.

## Configuration
- Macro IBEX_MEM_RESPONDER_ERR_INJ_EN.
- Defined:
  - err_inject_i is sampled at the grant cycle. A granted request with err_inject_i=1 gets err_o=1 and rdata_o=0, and its write is suppressed.
  - Latency and ordering are unchanged.
- Undefined:
  - err_inject_i is ignored.
  - err_o is asserted only for out-of-range requests.

## Test plan
- Write then read, Latency=1: write 32'hDEADBEEF to 0x10 (be=4'hF), then read 0x10. Both responses arrive one cycle after their grants; read rdata_o=32'hDEADBEEF, err_o=0.
- Byte enables: word 0x20 = 32'h11223344, then write 32'hAABBCCDD with be=4'b0101. A subsequent read returns 32'h11BB33DD.
- Backpressure and limit, Latency=3, MaxOutstanding=2: hold req_i high for 6 reads.
  - gnt_o pattern: 1,1,0,0,1,1,…; never more than 2 outstanding.
  - Responses arrive in order, one per grant.
  - With stall_i=1 for 4 cycles, there are no grants during the stall.
- Out of range, MemWords=1024, BaseAddr=0: write to 0x1000, then read 0x1000. Both responses have err_o=1 and rdata_o=0; word 0 is unchanged.
- Reset mid-operation, Latency=4: grant 2 reads, then pulse rst_ni=0 for one cycle. rvalid_o is never asserted for those reads; outstanding returns to 0; memory keeps earlier writes.
- Error injection (macro defined): write 32'h5 to 0x8 with err_inject_i=1. Response err_o=1; a subsequent read of 0x8 returns the old value. With the macro undefined, the same stimulus gives err_o=0 and the write takes effect.

Source files
------------

// File: rtl/ibex_mem_responder.sv
// Ibex req/gnt/rvalid memory responder with fixed-latency, in-order responses.
// Optional error injection enabled by defining IBEX_MEM_RESPONDER_ERR_INJ_EN.
module ibex_mem_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  input  logic        stall_i,
  input  logic        err_inject_i
);

  localparam int unsigned AW       = $clog2(MemWords);
  localparam logic [32:0] MemBytes = 33'(MemWords) << 2;

  logic [31:0]              mem_q [MemWords];
  logic [3:0]               outs_q, outs_d;
  logic [Latency-1:0]       vld_q, vld_d;
  logic [Latency-1:0]       err_q, err_d;
  logic [Latency-1:0][31:0] dat_q, dat_d;

  logic [32:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          inj;
  logic          resp_err;
  logic          mem_we;

`ifdef IBEX_MEM_RESPONDER_ERR_INJ_EN
  assign inj = err_inject_i;
`else
  logic unused_err_inject;
  assign unused_err_inject = err_inject_i;
  assign inj = 1'b0;
`endif

  // 33-bit subtraction so addresses below BaseAddr show up as a borrow
  assign offset   = {1'b0, addr_i} - {1'b0, BaseAddr};
  assign in_range = ~offset[32] & (offset < MemBytes);
  assign idx      = offset[AW+1:2];

  assign gnt_o    = req_i & ~stall_i & (outs_q < 4'(MaxOutstanding));
  assign resp_err = ~in_range | inj;
  assign mem_we   = gnt_o & we_i & ~resp_err;

  always_comb begin
    vld_d    = vld_q;
    err_d    = err_q;
    dat_d    = dat_q;
    vld_d[0] = gnt_o;
    err_d[0] = gnt_o & resp_err;
    dat_d[0] = (gnt_o & ~we_i & ~resp_err) ? mem_q[idx] : '0;
    for (int unsigned i = 1; i < Latency; i++) begin
      vld_d[i] = vld_q[i-1];
      err_d[i] = err_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    outs_d = outs_q + {3'b000, gnt_o} - {3'b000, vld_q[Latency-1]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      err_q  <= '0;
      dat_q  <= '0;
      outs_q <= '0;
    end else begin
      vld_q  <= vld_d;
      err_q  <= err_d;
      dat_q  <= dat_d;
      outs_q <= outs_d;
    end
  end

  // Memory contents survive reset
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be_i[k]) mem_q[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rvalid_o = vld_q[Latency-1];
  assign err_o    = err_q[Latency-1];
  assign rdata_o  = dat_q[Latency-1];

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Directed scoreboard bench for ibex_mem_responder (Latency=3, MaxOutstanding=2).
module tb_ibex_mem_responder;

  localparam int unsigned L    = 3;
  localparam int unsigned MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_ni, req_i, we_i, stall_i, err_inject_i;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o, rvalid_o, err_o;
  logic [31:0] rdata_o;

  ibex_mem_responder #(
    .MemWords(1024), .BaseAddr(32'h0), .Latency(L), .MaxOutstanding(MAXO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .stall_i(stall_i), .err_inject_i(err_inject_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          gcyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];
  int          outs = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        last_g;
  logic [31:0] last_rd;
  logic        last_err;
  logic        rec = 1'b0;
  logic        gp [16];
  int          gidx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One cycle: check response, check grant against the model, update the model
  task automatic step();
    exp_t e;
    logic exp_g;
    logic inj;
    int   w;
    @(negedge clk);
    if (rvalid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", {31'b0, rvalid_o}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("rdata", rdata_o, e.rdata);
        chk("err", {31'b0, err_o}, {31'b0, e.err});
        chk("latency", cyc, e.gcyc + L);
        last_rd  = rdata_o;
        last_err = err_o;
      end
    end else begin
      chk("idle_rdata", rdata_o, 32'h0);
    end
    exp_g = req_i & ~stall_i & (outs < MAXO);
    chk("gnt", {31'b0, gnt_o}, {31'b0, exp_g});
    last_g = gnt_o;
    if (rec && gidx < 16) begin
      gp[gidx] = gnt_o;
      gidx++;
    end
    if (exp_g) begin
`ifdef IBEX_MEM_RESPONDER_ERR_INJ_EN
      inj = err_inject_i;
`else
      inj = 1'b0;
`endif
      w       = int'(addr_i[31:2]);
      e.err   = (addr_i >= 32'h1000) | inj;
      e.rdata = (!we_i && !e.err) ? model[w] : 32'h0;
      e.gcyc  = cyc;
      sb.push_back(e);
      if (we_i && !e.err) begin
        if (!model.exists(w)) model[w] = 32'hxxxx_xxxx;
        for (int k = 0; k < 4; k++)
          if (be_i[k]) model[w][8*k +: 8] = wdata_i[8*k +: 8];
      end
    end
    if (!rst_ni) begin
      sb.delete();
      outs = 0;
    end else begin
      outs = outs + int'(exp_g) - int'(rvalid_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd);
    logic got;
    got     = 1'b0;
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = a;
    be_i    = be;
    wdata_i = wd;
    for (int n = 0; n < 20 && !got; n++) begin
      step();
      got = last_g;
    end
    if (!got) chk("grant_timeout", {31'b0, got}, 32'h1);
    req_i = 1'b0;
  endtask

  task automatic drain(input int n);
    req_i = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [5:0] pat6;
    logic [1:0] pat2;
    int         nstall;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; stall_i = 1'b0; err_inject_i = 1'b0;
    addr_i = '0; be_i = '0; wdata_i = '0;
    #1;
    step();
    step();
    chk("reset_rvalid", {31'b0, rvalid_o}, 32'h0);
    chk("reset_rdata", rdata_o, 32'h0);
    chk("reset_err", {31'b0, err_o}, 32'h0);
    chk("reset_gnt", {31'b0, gnt_o}, 32'h0);
    rst_ni = 1'b1;

    issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    issue(1'b0, 32'h10, 4'hF, 32'h0);
    drain(5);
    chk("raw_rdata", last_rd, 32'hDEADBEEF);
    chk("raw_err", {31'b0, last_err}, 32'h0);

    issue(1'b1, 32'h20, 4'hF, 32'h11223344);
    issue(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    drain(5);
    chk("be_rdata", last_rd, 32'h11BB33DD);

    rec = 1'b1; gidx = 0;
    for (int i = 0; i < 6; i++) issue(1'b0, (i % 2 == 0) ? 32'h10 : 32'h20, 4'h0, 32'h0);
    rec = 1'b0;
    pat6 = {gp[0], gp[1], gp[2], gp[3], gp[4], gp[5]};
    chk("limit_pattern", {26'b0, pat6}, {26'b0, 6'b110011});
    drain(5);

    stall_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10; nstall = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      nstall += int'(last_g);
    end
    chk("stall_grants", nstall, 0);
    stall_i = 1'b0;
    issue(1'b0, 32'h10, 4'h0, 32'h0);
    drain(5);
    chk("post_stall_rdata", last_rd, 32'hDEADBEEF);

    issue(1'b1, 32'h0, 4'hF, 32'h0BADF00D);
    issue(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF);
    drain(5);
    chk("oor_wr_err", {31'b0, last_err}, 32'h1);
    issue(1'b0, 32'h1000, 4'h0, 32'h0);
    drain(5);
    chk("oor_rd_err", {31'b0, last_err}, 32'h1);
    chk("oor_rd_rdata", last_rd, 32'h0);
    issue(1'b0, 32'h0, 4'h0, 32'h0);
    drain(5);
    chk("word0_kept", last_rd, 32'h0BADF00D);

    issue(1'b1, 32'h8, 4'hF, 32'h12345678);
    err_inject_i = 1'b1;
    issue(1'b1, 32'h8, 4'hF, 32'h5);
    err_inject_i = 1'b0;
    drain(5);
`ifdef IBEX_MEM_RESPONDER_ERR_INJ_EN
    chk("inj_err", {31'b0, last_err}, 32'h1);
`else
    chk("inj_err", {31'b0, last_err}, 32'h0);
`endif
    issue(1'b0, 32'h8, 4'h0, 32'h0);
    drain(5);
`ifdef IBEX_MEM_RESPONDER_ERR_INJ_EN
    chk("inj_rdata", last_rd, 32'h12345678);
`else
    chk("inj_rdata", last_rd, 32'h5);
`endif

    issue(1'b0, 32'h10, 4'h0, 32'h0);
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    drain(6);
    rec = 1'b1; gidx = 0;
    issue(1'b0, 32'h20, 4'h0, 32'h0);
    issue(1'b0, 32'h10, 4'h0, 32'h0);
    rec = 1'b0;
    pat2 = {gp[0], gp[1]};
    chk("post_reset_gnt", {30'b0, pat2}, {30'b0, 2'b11});
    drain(5);
    chk("post_reset_mem", last_rd, 32'hDEADBEEF);

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
